// File: rtl/dma_pkg.sv
// Shared types and constants for the tile-fetch DMA: op codes, region map, FSM states.
package dma_pkg;

    typedef enum logic [2:0] {
        OP_INF  = 3'd0,
        OP_FMI  = 3'd1,
        OP_KEXP = 3'd2,
        OP_KPW  = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] OFFSET_INF_CONV = 32'h1000_0000;
    localparam logic [31:0] OFFSET_FMI      = 32'h2000_0000;
    localparam logic [31:0] OFFSET_KEX      = 32'h3000_0000;
    localparam logic [31:0] OFFSET_KPW      = 32'h4000_0000;

    localparam logic [31:0] REGION_BASE [4] = '{OFFSET_INF_CONV, OFFSET_FMI, OFFSET_KEX, OFFSET_KPW};

    function automatic logic op_reserved(input logic [2:0] op);
        return op > 3'(OP_KPW);
    endfunction

    function automatic logic [31:0] region_base(input logic [2:0] op);
        return REGION_BASE[op[1:0]];
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Tile address walker: column/row counters plus a row-start accumulator.
module dma_addr_gen #(
    parameter int unsigned AW = 32,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] region_base,
    input  logic [AW-1:0] src_base,
    input  logic [LW-1:0] row_len,
    input  logic [LW-1:0] n_rows,
    input  logic [AW-1:0] row_stride,
    input  logic          issue,
    output logic [AW-1:0] addr_c,
    output logic          valid_c,
    output logic          last_c
);

    logic [LW-1:0] col_q, col_d;
    logic [LW-1:0] row_q, row_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] nrows_q, nrows_d;
    logic [AW-1:0] row_addr_q, row_addr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] stride_q, stride_d;
    logic          valid_q, valid_d;

    assign addr_c  = base_q + row_addr_q + AW'(col_q);
    assign valid_c = valid_q;
    assign last_c  = valid_q && (col_q == len_q - LW'(1)) && (row_q == nrows_q - LW'(1));

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        len_d      = len_q;
        nrows_d    = nrows_q;
        row_addr_d = row_addr_q;
        base_d     = base_q;
        stride_d   = stride_q;
        valid_d    = valid_q;
        if (start) begin
            col_d      = '0;
            row_d      = '0;
            len_d      = row_len;
            nrows_d    = n_rows;
            row_addr_d = src_base;
            base_d     = region_base;
            stride_d   = row_stride;
            valid_d    = 1'b1;
        end else if (issue && valid_q) begin
            // Wrapping the column moves to the next row start.
            if (col_q == len_q - LW'(1)) begin
                col_d      = '0;
                row_d      = row_q + LW'(1);
                row_addr_d = row_addr_q + stride_q;
                if (last_c) begin
                    valid_d = 1'b0;
                end
            end else begin
                col_d = col_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            len_q      <= '0;
            nrows_q    <= '0;
            row_addr_q <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            len_q      <= len_d;
            nrows_q    <= nrows_d;
            row_addr_q <= row_addr_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/dma_tile_fetch.sv
// Tile-fetch DMA: walks a strided 2-D tile in external memory with several reads
// in flight and streams the in-order responses into consecutive local RAM words.
module dma_tile_fetch
    import dma_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned RAW     = 16,
    parameter int unsigned LW      = 8,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_op,
    input  logic [2:0]     op,
    input  logic [AW-1:0]  src_base,
    input  logic [LW-1:0]  row_len,
    input  logic [LW-1:0]  n_rows,
    input  logic [AW-1:0]  row_stride,
    input  logic [RAW-1:0] dst_base,
    output logic           busy,
    output logic           e_op,
    output logic           err,
    output logic           r_request_extmem,
    output logic [AW-1:0]  addr_extmem,
    input  logic           r_valid_extmem,
    input  logic [DW-1:0]  data_extmem,
    output logic           write,
    output logic [RAW-1:0] ram_addr,
    output logic [DW-1:0]  ram_data
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    state_e         state_q, state_d;
    logic           busy_q, busy_d;
    logic           e_op_q, e_op_d;
    logic           err_q, err_d;
    logic           err_flag_q, err_flag_d;
    logic           req_q, req_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           write_q, write_d;
    logic [RAW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0]  ram_data_q, ram_data_d;
    logic [RAW-1:0] dst_q, dst_d;
    logic [RAW-1:0] wcount_q, wcount_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;

    logic           accept_c, reserved_c, empty_c, gen_start_c;
    logic           issue_c, resp_ok_c, stray_c;
    logic [AW-1:0]  gen_addr_c;
    logic           gen_valid_c, gen_last_c;

    assign accept_c    = (state_q == ST_IDLE) && s_op;
    assign reserved_c  = op_reserved(op);
    assign empty_c     = (row_len == '0) || (n_rows == '0);
    assign gen_start_c = accept_c && !reserved_c && !empty_c;
    assign issue_c     = (state_q == ST_ISSUE) && gen_valid_c && (outstanding_q < OW'(MAX_OUT));
    assign resp_ok_c   = r_valid_extmem && (outstanding_q != '0);
    // Responses with nothing in flight are only an error while an operation runs.
    assign stray_c     = r_valid_extmem && (outstanding_q == '0) && (state_q != ST_IDLE);

    dma_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .start       (gen_start_c),
        .region_base (AW'(region_base(op))),
        .src_base    (src_base),
        .row_len     (row_len),
        .n_rows      (n_rows),
        .row_stride  (row_stride),
        .issue       (issue_c),
        .addr_c      (gen_addr_c),
        .valid_c     (gen_valid_c),
        .last_c      (gen_last_c)
    );

    always_comb begin
        state_d       = state_q;
        err_flag_d    = err_flag_q;
        dst_d         = dst_q;
        wcount_d      = wcount_q;
        outstanding_d = outstanding_q + OW'(issue_c) - OW'(resp_ok_c);
        req_d         = issue_c;
        addr_d        = issue_c ? gen_addr_c : addr_q;
        write_d       = resp_ok_c;
        ram_addr_d    = resp_ok_c ? dst_q + wcount_q : ram_addr_q;
        ram_data_d    = resp_ok_c ? data_extmem : ram_data_q;
        if (resp_ok_c) begin
            wcount_d = wcount_q + RAW'(1);
        end
        if (stray_c) begin
            err_flag_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_op) begin
                    state_d    = (reserved_c || empty_c) ? ST_DONE : ST_ISSUE;
                    dst_d      = dst_base;
                    wcount_d   = '0;
                    err_flag_d = reserved_c;
                end
            end
            ST_ISSUE: begin
                if (issue_c && gen_last_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leaving on the last response lands DONE on the cycle of the final write.
                if (outstanding_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        e_op_d = (state_q == ST_DONE);
        err_d  = (state_q == ST_DONE) && err_flag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            e_op_q        <= 1'b0;
            err_q         <= 1'b0;
            err_flag_q    <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            dst_q         <= '0;
            wcount_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            e_op_q        <= e_op_d;
            err_q         <= err_d;
            err_flag_q    <= err_flag_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            dst_q         <= dst_d;
            wcount_q      <= wcount_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign busy             = busy_q;
    assign e_op             = e_op_q;
    assign err              = err_q;
    assign r_request_extmem = req_q;
    assign addr_extmem      = addr_q;
    assign write            = write_q;
    assign ram_addr         = ram_addr_q;
    assign ram_data         = ram_data_q;

endmodule

// File: tb/tb_dma_tile_fetch.sv
// Directed bench for dma_tile_fetch with a latency-programmable memory model
// and request/write scoreboards filled when each operation is started.
module tb_dma_tile_fetch;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 32;
    localparam int unsigned RAW     = 16;
    localparam int unsigned LW      = 8;
    localparam int unsigned MAX_OUT = 4;

    localparam logic [31:0] REGION [4] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};

    logic           clk;
    logic           rst;
    logic           s_op;
    logic [2:0]     op;
    logic [AW-1:0]  src_base;
    logic [LW-1:0]  row_len;
    logic [LW-1:0]  n_rows;
    logic [AW-1:0]  row_stride;
    logic [RAW-1:0] dst_base;
    logic           busy;
    logic           e_op;
    logic           err;
    logic           r_request_extmem;
    logic [AW-1:0]  addr_extmem;
    logic           r_valid_extmem;
    logic [DW-1:0]  data_extmem;
    logic           write;
    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_data;

    dma_tile_fetch #(
        .DW (DW), .AW (AW), .RAW (RAW), .LW (LW), .MAX_OUT (MAX_OUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_op             (s_op),
        .op               (op),
        .src_base         (src_base),
        .row_len          (row_len),
        .n_rows           (n_rows),
        .row_stride       (row_stride),
        .dst_base         (dst_base),
        .busy             (busy),
        .e_op             (e_op),
        .err              (err),
        .r_request_extmem (r_request_extmem),
        .addr_extmem      (addr_extmem),
        .r_valid_extmem   (r_valid_extmem),
        .data_extmem      (data_extmem),
        .write            (write),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_req [$];
    logic [47:0] exp_wr  [$];
    pend_t       pending [$];

    int   cyc = 0;
    int   lat = 1;
    int   req_cnt = 0, wr_cnt = 0, eop_cnt = 0, rv_cnt = 0, gaps = 0;
    int   first_req_cyc = 0, prev_req_cyc = 0, last_wr_cyc = 0, eop_cyc = 0, start_cyc = 0;
    logic got_first = 1'b0;
    logic eop_err   = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Memory model and output monitor, sampled 1 time unit after each rising edge.
    initial begin
        pend_t p;
        r_valid_extmem = 1'b0;
        data_extmem    = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (r_request_extmem) begin
                req_cnt++;
                check("req_expected", 64'(exp_req.size() != 0), 64'd1);
                if (exp_req.size() != 0) begin
                    check("req_addr", 64'(addr_extmem), 64'(exp_req.pop_front()));
                end
                if (!got_first) begin
                    got_first     = 1'b1;
                    first_req_cyc = cyc;
                end else if (cyc - prev_req_cyc > 1) begin
                    gaps++;
                end
                prev_req_cyc = cyc;
                pending.push_back('{addr: addr_extmem, due: 32'(cyc + lat)});
                check("outstanding_le_max", 64'(pending.size() <= MAX_OUT), 64'd1);
            end
            if (write) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    check("wr_addr_data", 64'({ram_addr, ram_data}), 64'(exp_wr.pop_front()));
                end
            end
            if (e_op) begin
                eop_cnt++;
                eop_cyc = cyc;
                eop_err = err;
            end
            if (pending.size() != 0 && pending[0].due <= 32'(cyc)) begin
                p = pending.pop_front();
                r_valid_extmem = 1'b1;
                data_extmem    = mem_word(p.addr);
                rv_cnt++;
            end else begin
                r_valid_extmem = 1'b0;
                data_extmem    = '0;
            end
        end
    end

    task automatic start_op(input logic [2:0] o, input logic [31:0] src, input int rl, input int nr,
                            input logic [31:0] stride, input logic [15:0] dst);
        logic [31:0] a;
        int          i;
        i = 0;
        @(negedge clk);
        op         = o;
        src_base   = src;
        row_len    = 8'(rl);
        n_rows     = 8'(nr);
        row_stride = stride;
        dst_base   = dst;
        if (o < 3'd4) begin
            for (int r = 0; r < nr; r++) begin
                for (int c = 0; c < rl; c++) begin
                    a = REGION[o[1:0]] + src + 32'(r) * stride + 32'(c);
                    exp_req.push_back(a);
                    exp_wr.push_back({dst + 16'(i), mem_word(a)});
                    i++;
                end
            end
        end
        got_first = 1'b0;
        s_op      = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        s_op = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] src, input int rl, input int nr,
                          input logic [31:0] stride, input logic [15:0] dst,
                          input logic exp_err, input int budget);
        int e0, r0;
        e0 = eop_cnt;
        r0 = req_cnt;
        start_op(o, src, rl, nr, stride, dst);
        for (int k = 0; k < budget && eop_cnt == e0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("eop_once", 64'(eop_cnt - e0), 64'd1);
        check("err_at_eop", 64'(eop_err), 64'(exp_err));
        check("busy_low_after", 64'(busy), 64'd0);
        check("req_queue_drained", 64'(exp_req.size()), 64'd0);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        if (rl * nr == 0 || o >= 3'd4) begin
            check("no_requests", 64'(req_cnt - r0), 64'd0);
            check("eop_latency", 64'(eop_cyc - start_cyc), 64'd2);
        end else begin
            check("req_count", 64'(req_cnt - r0), 64'(rl * nr));
            check("first_req_latency", 64'(first_req_cyc - start_cyc), 64'd2);
            check("eop_after_last_write", 64'(eop_cyc - last_wr_cyc), 64'd1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_e_op"}, 64'(e_op), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_req"}, 64'(r_request_extmem), 64'd0);
        check({tag, "_write"}, 64'(write), 64'd0);
    endtask

    initial begin
        int g0, w0, e0, rv0;
        rst        = 1'b1;
        s_op       = 1'b0;
        op         = '0;
        src_base   = '0;
        row_len    = '0;
        n_rows     = '0;
        row_stride = '0;
        dst_base   = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        lat = 1;
        run_op(3'd1, 32'd0, 4, 1, 32'd0, 16'h0010, 1'b0, 100);
        lat = 2;
        run_op(3'd3, 32'd2, 3, 2, 32'd10, 16'h0040, 1'b0, 100);

        lat = 6;
        g0  = gaps;
        run_op(3'd0, 32'h30, 16, 1, 32'd0, 16'h0100, 1'b0, 400);
        check("request_gaps", 64'(gaps - g0 > 0), 64'd1);

        lat = 1;
        run_op(3'd5, 32'd0, 4, 1, 32'd0, 16'h0000, 1'b1, 50);
        run_op(3'd0, 32'd0, 0, 3, 32'd0, 16'h0000, 1'b0, 50);
        run_op(3'd2, 32'd7, 2, 2, 32'h100, 16'hFFFE, 1'b0, 100);

        // Abort mid-transfer, then let in-flight responses arrive stale.
        lat = 6;
        w0  = wr_cnt;
        e0  = eop_cnt;
        start_op(3'd1, 32'd0, 8, 1, 32'd0, 16'h0200);
        for (int k = 0; k < 200 && wr_cnt - w0 < 3; k++) @(negedge clk);
        check("writes_before_reset", 64'(wr_cnt - w0), 64'd3);
        rst = 1'b1;
        exp_req.delete();
        exp_wr.delete();
        rv0 = rv_cnt;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        w0  = wr_cnt;
        repeat (12) @(negedge clk);
        check("stale_responses_seen", 64'(rv_cnt - rv0 > 0), 64'd1);
        check("no_writes_after_reset", 64'(wr_cnt - w0), 64'd0);
        check("no_eop_after_reset", 64'(eop_cnt - e0), 64'd0);
        check("idle_after_reset", 64'(busy), 64'd0);

        lat = 2;
        run_op(3'd2, 32'd5, 4, 1, 32'd0, 16'h0000, 1'b0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_tile_fetch.md
Name: dma_tile_fetch

Overview:
- Parametrised next-generation DMA. Fetches a 2-D tile (n_rows × row_len words, external row stride) from one of four external-memory regions and writes it sequentially into on-chip RAM.
- Keeps up to MAX_OUT read requests in flight, so it does not stall on each word.
- Sits between the controller, which drives s_op/op and the tile descriptor, and the external-memory read port plus the local RAM write port.

Parameters:
- DW, 32, data word width (external and RAM).
- AW, 32, external address width.
- RAW, 16, local RAM address width.
- LW, 8, width of the row_len and n_rows fields.
- MAX_OUT, 4, maximum outstanding external reads (power of 2, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_op  in  1  start; sampled only in IDLE
- op  in  3  region select: 0 inf_conv, 1 fmi, 2 kexp, 3 kpw, 4-7 reserved
- src_base  in  AW  word offset inside the selected region
- row_len  in  LW  words per row
- n_rows  in  LW  rows per tile
- row_stride  in  AW  external word distance between row starts
- dst_base  in  RAW  first local RAM address
- busy  out  1  high from start acceptance until e_op
- e_op  out  1  one-cycle end-of-operation pulse
- err  out  1  valid with e_op: reserved op, or unexpected response
- r_request_extmem  out  1  one read request per cycle asserted
- addr_extmem  out  AW  request address, valid with r_request_extmem
- r_valid_extmem  in  1  read response valid; in-order; ≥1 cycle after its request
- data_extmem  in  DW  response data
- write  out  1  RAM write strobe
- ram_addr  out  RAW  RAM write address
- ram_data  out  DW  RAM write data

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- A reset mid-operation aborts immediately. Responses arriving after reset are ignored and do not set err.
- FSM IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE:
  - On s_op=1, latch all descriptor fields and set busy=1 the next cycle.
  - op ≥ 4, or row_len=0, or n_rows=0: go directly to DONE. err=1 only for a reserved op.
  - s_op is ignored outside IDLE. s_op held high after DONE starts a new operation on returning to IDLE.
- Addressing:
  - addr = REGION_BASE[op] + row_addr + col.
  - row_addr starts at src_base and advances by row_stride when col wraps from row_len-1 to 0.
  - All arithmetic is modulo 2^AW.
- ISSUE:
  - Assert r_request_extmem whenever outstanding < MAX_OUT.
  - After the last address (row n_rows-1, col row_len-1) is issued, go to DRAIN.
- Outstanding counter:
  - +1 on request, -1 on r_valid_extmem.
  - Both in the same cycle leaves it unchanged.
  - Saturation at MAX_OUT blocks further issue.
- Responses:
  - Each r_valid_extmem with outstanding>0 produces write=1 on the next cycle, with ram_data = data_extmem registered and ram_addr = dst_base + wcount.
  - ram_addr wraps modulo 2^RAW.
  - wcount increments per write.
- Unexpected response: r_valid_extmem when outstanding=0 (and not in the first cycle after reset) is dropped and sets sticky err.
- DRAIN: wait for outstanding=0 and the final write issued, then go to DONE.
- DONE: e_op=1 and err valid for one cycle; busy drops the same cycle; next state IDLE.
- Latency: first request appears 2 cycles after s_op is sampled. e_op appears 1 cycle after the last write.
- Total words transferred = row_len × n_rows (maximum (2^LW-1)^2).

Decomposition:
- dma_pkg: op enum (OP_INF, OP_FMI, OP_KEXP, OP_KPW), REGION_BASE constant array (offset_inf_conv, offset_fmi, offset_kex, offset_kpw), FSM state enum.
- Sub-module dma_addr_gen: col/row counters plus row_addr accumulator. Outputs addr, valid, last; advances on an issue input.

Test Plan:
- op=1, src_base=0, row_len=4, n_rows=1, dst_base=0x10, memory latency 1 → 4 writes to 0x10..0x13 with fmi words 0..3, e_op once, err=0.
- op=3, src_base=2, row_len=3, n_rows=2, row_stride=10 → requests at REGION_BASE[3]+{2,3,4,12,13,14}, RAM addresses dst_base..+5 in order.
- Latency 6 cycles, MAX_OUT=4, row_len=16 → outstanding never exceeds 4, request gaps occur, 16 correct writes.
- op=5 → e_op 2 cycles after s_op with err=1, no requests. row_len=0 → e_op with err=0, no requests.
- dst_base=0xFFFE, 4 words → ram_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst asserted after 3 of 8 writes, then stale r_valid pulses → outputs 0, no writes. A new s_op then completes normally with err=0.
